// File: rtl/pong_pkg.sv
// Shared Pong definitions: ball FSM states and playfield geometry used by the
// ball, the paddles and the top level.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        SCORED = 2'd2
    } ball_state_t;

    localparam logic [9:0] TOP_BOUND    = 10'd136;
    localparam logic [9:0] BOTTOM_BOUND = 10'd512;
    localparam logic [9:0] SCREEN_W     = 10'd800;

endpackage

// File: rtl/ball_render.sv
// Square sprite pixel test: drives COLOR while the scan position lies inside the
// BALL_SIZE x BALL_SIZE box whose top-left corner is (box_x_i, box_y_i).
module ball_render #(
    parameter int          BALL_SIZE = 10,
    parameter logic [11:0] COLOR     = 12'hfff
) (
    input  logic [9:0]  pix_x_i,
    input  logic [9:0]  pix_y_i,
    input  logic [9:0]  box_x_i,
    input  logic [9:0]  box_y_i,
    output logic [11:0] rgb_o
);

    localparam logic [10:0] SIZE_C = 11'(BALL_SIZE);

    logic [10:0] x_end_s;
    logic [10:0] y_end_s;
    logic        hit_s;

    // One extra bit keeps the box end from wrapping near the right/bottom edge.
    assign x_end_s = {1'b0, box_x_i} + SIZE_C;
    assign y_end_s = {1'b0, box_y_i} + SIZE_C;

    // Half-open interval test on both axes, then colour select.
    always_comb begin
        hit_s = (pix_x_i >= box_x_i) && ({1'b0, pix_x_i} < x_end_s) &&
                (pix_y_i >= box_y_i) && ({1'b0, pix_y_i} < y_end_s);
        if (hit_s) begin
            rgb_o = COLOR;
        end else begin
            rgb_o = 12'h000;
        end
    end

endmodule

// File: rtl/ball_controller.sv
// Pong ball: position/velocity per frame tick, wall bounces, one-shot paddle
// deflection, scoring pulses and the IDLE -> PLAY -> SCORED serve sequence.
module ball_controller #(
    parameter int          BALL_SIZE    = 10,
    parameter int          START_X      = 395,
    parameter int          START_Y      = 319,
    parameter int          XSPEED       = 2,
    parameter int          MAX_XSPEED   = 6,
    parameter int          YSPEED       = 2,
    parameter int          TOP_BOUND    = int'(pong_pkg::TOP_BOUND),
    parameter int          BOTTOM_BOUND = int'(pong_pkg::BOTTOM_BOUND),
    parameter int          RIGHT_GOAL   = 799,
    parameter int          HOLD_TICKS   = 60,
    parameter logic [11:0] COLOR        = 12'hfff
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        serve,
    input  logic        l_tophit,
    input  logic        l_midhit,
    input  logic        l_bothit,
    input  logic        r_tophit,
    input  logic        r_midhit,
    input  logic        r_bothit,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic        score_left,
    output logic        score_right,
    output logic        playing,
    output logic [11:0] rgb
);
    import pong_pkg::*;

    localparam logic [9:0]         START_X_C  = 10'(START_X);
    localparam logic [9:0]         START_Y_C  = 10'(START_Y);
    localparam logic [2:0]         XSPEED_C   = 3'(XSPEED);
    localparam logic [2:0]         MAXXS_C    = 3'(MAX_XSPEED);
    localparam logic signed [3:0]  YSPEED_C   = 4'(YSPEED);
    localparam logic signed [10:0] SIZE_C     = 11'(BALL_SIZE);
    localparam logic signed [10:0] TOP_C      = 11'(TOP_BOUND);
    localparam logic signed [10:0] BOTTOM_C   = 11'(BOTTOM_BOUND);
    localparam logic signed [10:0] GOAL_C     = 11'(RIGHT_GOAL);
    localparam logic [5:0]         HOLD_END_C = 6'(HOLD_TICKS - 1);

    ball_state_t       state_q, state_d;
    logic [9:0]        ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [2:0]        vx_mag_q, vx_mag_d;
    logic              dir_right_q, dir_right_d;
    logic signed [3:0] vy_q, vy_d;
    logic [5:0]        hold_q, hold_d;
    logic              score_l_q, score_l_d, score_r_q, score_r_d;
    logic              playing_q;

    logic              hit_top_s, hit_mid_s, hit_bot_s;
    logic signed [3:0] vy_abs_s;
    logic signed [10:0] next_x_s, next_y_s;

    // Next-state logic for the serve/play/score sequence and the per-tick update.
    always_comb begin
        state_d     = state_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        vx_mag_d    = vx_mag_q;
        dir_right_d = dir_right_q;
        vy_d        = vy_q;
        hold_d      = hold_q;
        score_l_d   = 1'b0;
        score_r_d   = 1'b0;
        hit_top_s   = 1'b0;
        hit_mid_s   = 1'b0;
        hit_bot_s   = 1'b0;
        vy_abs_s    = 4'sd0;
        next_x_s    = 11'sd0;
        next_y_s    = 11'sd0;

        case (state_q)
            IDLE: begin
                ball_x_d = START_X_C;
                ball_y_d = START_Y_C;
                if (serve) begin
                    state_d  = PLAY;
                    vx_mag_d = XSPEED_C;
                    vy_d     = 4'sd0;
                end else begin
                    state_d  = IDLE;
                end
            end
            PLAY: begin
                if (en) begin
                    // Only the paddle the ball is heading toward is honoured, so a
                    // level-held flag deflects exactly once.
                    if (dir_right_q) begin
                        hit_top_s = r_tophit;
                        hit_mid_s = r_midhit;
                        hit_bot_s = r_bothit;
                    end else begin
                        hit_top_s = l_tophit;
                        hit_mid_s = l_midhit;
                        hit_bot_s = l_bothit;
                    end
                    if (hit_top_s || hit_mid_s || hit_bot_s) begin
                        dir_right_d = ~dir_right_q;
                        vx_mag_d    = (vx_mag_q >= MAXXS_C) ? MAXXS_C : vx_mag_q + 3'd1;
                        if (hit_mid_s) begin
                            vy_d = 4'sd0;
                        end else if (hit_top_s) begin
                            vy_d = -YSPEED_C;
                        end else begin
                            vy_d = YSPEED_C;
                        end
                    end else begin
                        dir_right_d = dir_right_q;
                    end

                    if (dir_right_d) begin
                        next_x_s = $signed({1'b0, ball_x_q}) + $signed({8'd0, vx_mag_d});
                    end else begin
                        next_x_s = $signed({1'b0, ball_x_q}) - $signed({8'd0, vx_mag_d});
                    end
                    vy_abs_s = vy_d[3] ? -vy_d : vy_d;
                    next_y_s = $signed({1'b0, ball_y_q}) + $signed({{7{vy_d[3]}}, vy_d});

                    if (next_x_s <= 11'sd0) begin
                        ball_x_d    = 10'd0;
                        score_r_d   = 1'b1;
                        state_d     = SCORED;
                        dir_right_d = 1'b0;
                        hold_d      = 6'd0;
                    end else if ((next_x_s + SIZE_C) >= GOAL_C) begin
                        ball_x_d    = 10'(GOAL_C - SIZE_C);
                        score_l_d   = 1'b1;
                        state_d     = SCORED;
                        dir_right_d = 1'b1;
                        hold_d      = 6'd0;
                    end else begin
                        ball_x_d = next_x_s[9:0];
                        if (next_y_s <= TOP_C) begin
                            ball_y_d = 10'(TOP_C);
                            vy_d     = vy_abs_s;
                        end else if ((next_y_s + SIZE_C) >= BOTTOM_C) begin
                            ball_y_d = 10'(BOTTOM_C - SIZE_C);
                            vy_d     = -vy_abs_s;
                        end else begin
                            ball_y_d = next_y_s[9:0];
                        end
                    end
                end else begin
                    state_d = PLAY;
                end
            end
            SCORED: begin
                if (en) begin
                    if (hold_q == HOLD_END_C) begin
                        state_d  = IDLE;
                        hold_d   = 6'd0;
                        ball_x_d = START_X_C;
                        ball_y_d = START_Y_C;
                    end else begin
                        hold_d = hold_q + 6'd1;
                    end
                end else begin
                    state_d = SCORED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, kinematics and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ball_x_q    <= START_X_C;
            ball_y_q    <= START_Y_C;
            vx_mag_q    <= XSPEED_C;
            dir_right_q <= 1'b1;
            vy_q        <= 4'sd0;
            hold_q      <= 6'd0;
            score_l_q   <= 1'b0;
            score_r_q   <= 1'b0;
            playing_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            vx_mag_q    <= vx_mag_d;
            dir_right_q <= dir_right_d;
            vy_q        <= vy_d;
            hold_q      <= hold_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            playing_q   <= (state_d == PLAY);
        end
    end

    assign ball_x      = ball_x_q;
    assign ball_y      = ball_y_q;
    assign score_left  = score_l_q;
    assign score_right = score_r_q;
    assign playing     = playing_q;

    ball_render #(
        .BALL_SIZE (BALL_SIZE),
        .COLOR     (COLOR)
    ) u_render (
        .pix_x_i (x),
        .pix_y_i (y),
        .box_x_i (ball_x_q),
        .box_y_i (ball_y_q),
        .rgb_o   (rgb)
    );

endmodule

// File: tb/tb_ball_controller.sv
// Bench for ball_controller: behavioural model feeding a scoreboard every cycle,
// plus a table of hand-computed checkpoints and a few hand-written corner cases.
module tb_ball_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, serve;
    logic        l_tophit, l_midhit, l_bothit;
    logic        r_tophit, r_midhit, r_bothit;
    logic [9:0]  x, y;
    logic [9:0]  ball_x, ball_y;
    logic        score_left, score_right, playing;
    logic [11:0] rgb;

    ball_controller dut (
        .clk(clk), .reset(reset), .en(en), .serve(serve),
        .l_tophit(l_tophit), .l_midhit(l_midhit), .l_bothit(l_bothit),
        .r_tophit(r_tophit), .r_midhit(r_midhit), .r_bothit(r_bothit),
        .x(x), .y(y), .ball_x(ball_x), .ball_y(ball_y),
        .score_left(score_left), .score_right(score_right),
        .playing(playing), .rgb(rgb)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int x; int y; bit play; bit sl; bit sr;
    } exp_t;
    exp_t sb_q[$];

    // flags are {top, mid, bot}
    typedef struct {
        bit serve; bit en; int cnt; bit [2:0] lf; bit [2:0] rf;
        int ex; int ey; bit play; bit sl; bit sr;
    } vec_t;
    vec_t vecs[$];

    int m_state, m_x, m_y, m_vx, m_vy, m_hold;
    bit m_dir, m_sl, m_sr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_x = 395; m_y = 319; m_vx = 2; m_vy = 0; m_hold = 0;
        m_dir = 1'b1; m_sl = 1'b0; m_sr = 1'b0;
    endtask

    task automatic model_step(input bit e, input bit s, input bit [2:0] lf, input bit [2:0] rf);
        bit [2:0] hf;
        int nx, ny, av;
        m_sl = 1'b0; m_sr = 1'b0;
        if (m_state == 0) begin
            m_x = 395; m_y = 319;
            if (s) begin m_state = 1; m_vx = 2; m_vy = 0; end
        end else if (m_state == 1 && e) begin
            hf = m_dir ? rf : lf;
            if (hf != 3'b000) begin
                m_dir = !m_dir;
                m_vx = (m_vx + 1 > 6) ? 6 : m_vx + 1;
                m_vy = hf[1] ? 0 : (hf[2] ? -2 : 2);
            end
            nx = m_dir ? m_x + m_vx : m_x - m_vx;
            if (nx <= 0) begin
                m_x = 0; m_sr = 1'b1; m_state = 2; m_dir = 1'b0; m_hold = 0;
            end else if (nx + 10 >= 799) begin
                m_x = 789; m_sl = 1'b1; m_state = 2; m_dir = 1'b1; m_hold = 0;
            end else begin
                m_x = nx;
                ny = m_y + m_vy;
                av = (m_vy < 0) ? -m_vy : m_vy;
                if (ny <= 136) begin m_y = 136; m_vy = av; end
                else if (ny + 10 >= 512) begin m_y = 502; m_vy = -av; end
                else m_y = ny;
            end
        end else if (m_state == 2 && e) begin
            if (m_hold == 59) begin m_state = 0; m_hold = 0; m_x = 395; m_y = 319; end
            else m_hold++;
        end
    endtask

    task automatic cycle(input bit e, input bit s, input bit [2:0] lf, input bit [2:0] rf);
        exp_t ex;
        en = e; serve = s;
        {l_tophit, l_midhit, l_bothit} = lf;
        {r_tophit, r_midhit, r_bothit} = rf;
        model_step(e, s, lf, rf);
        sb_q.push_back(exp_t'{m_x, m_y, (m_state == 1), m_sl, m_sr});
        @(posedge clk); #1;
        ex = sb_q.pop_front();
        chk("sb_ball_x", int'(ball_x), ex.x);
        chk("sb_ball_y", int'(ball_y), ex.y);
        chk("sb_playing", int'(playing), int'(ex.play));
        chk("sb_score_left", int'(score_left), int'(ex.sl));
        chk("sb_score_right", int'(score_right), int'(ex.sr));
    endtask

    function automatic vec_t row(bit s, bit e, int c, bit [2:0] lf, bit [2:0] rf,
                                 int ex, int ey, bit p, bit sl, bit sr);
        vec_t v;
        v.serve = s; v.en = e; v.cnt = c; v.lf = lf; v.rf = rf;
        v.ex = ex; v.ey = ey; v.play = p; v.sl = sl; v.sr = sr;
        return v;
    endfunction

    initial begin
        int dxs[6];
        int dys[6];
        int px, py, exp_rgb;

        vecs.push_back(row(0, 0, 1,   3'b000, 3'b000, 395, 319, 0, 0, 0));
        vecs.push_back(row(1, 0, 1,   3'b000, 3'b000, 395, 319, 1, 0, 0));
        vecs.push_back(row(0, 1, 1,   3'b000, 3'b000, 397, 319, 1, 0, 0));
        vecs.push_back(row(0, 1, 195, 3'b000, 3'b000, 787, 319, 1, 0, 0));
        vecs.push_back(row(0, 1, 1,   3'b000, 3'b000, 789, 319, 0, 1, 0));
        vecs.push_back(row(0, 0, 1,   3'b000, 3'b000, 789, 319, 0, 0, 0));
        vecs.push_back(row(1, 1, 59,  3'b000, 3'b000, 789, 319, 0, 0, 0));
        vecs.push_back(row(0, 1, 1,   3'b000, 3'b000, 395, 319, 0, 0, 0));
        vecs.push_back(row(1, 1, 1,   3'b000, 3'b000, 395, 319, 1, 0, 0));
        vecs.push_back(row(0, 1, 1,   3'b000, 3'b001, 392, 321, 1, 0, 0));
        vecs.push_back(row(0, 1, 90,  3'b000, 3'b001, 122, 501, 1, 0, 0));
        vecs.push_back(row(0, 1, 1,   3'b000, 3'b001, 119, 502, 1, 0, 0));
        vecs.push_back(row(0, 1, 1,   3'b000, 3'b000, 116, 500, 1, 0, 0));
        vecs.push_back(row(0, 1, 38,  3'b000, 3'b000, 2,   424, 1, 0, 0));
        vecs.push_back(row(0, 1, 1,   3'b000, 3'b000, 0,   424, 0, 0, 1));
        vecs.push_back(row(0, 0, 1,   3'b000, 3'b000, 0,   424, 0, 0, 0));
        vecs.push_back(row(0, 1, 60,  3'b000, 3'b000, 395, 319, 0, 0, 0));
        vecs.push_back(row(1, 0, 1,   3'b000, 3'b000, 395, 319, 1, 0, 0));
        vecs.push_back(row(0, 1, 171, 3'b000, 3'b000, 53,  319, 1, 0, 0));
        vecs.push_back(row(0, 1, 1,   3'b100, 3'b000, 56,  317, 1, 0, 0));
        vecs.push_back(row(0, 1, 5,   3'b100, 3'b000, 71,  307, 1, 0, 0));
        vecs.push_back(row(0, 1, 85,  3'b000, 3'b000, 326, 137, 1, 0, 0));
        vecs.push_back(row(0, 1, 1,   3'b000, 3'b000, 329, 136, 1, 0, 0));
        vecs.push_back(row(0, 1, 1,   3'b000, 3'b000, 332, 138, 1, 0, 0));
        vecs.push_back(row(0, 1, 1,   3'b000, 3'b010, 328, 138, 1, 0, 0));
        vecs.push_back(row(0, 1, 1,   3'b010, 3'b000, 333, 138, 1, 0, 0));
        vecs.push_back(row(0, 1, 1,   3'b000, 3'b010, 327, 138, 1, 0, 0));
        vecs.push_back(row(0, 1, 1,   3'b010, 3'b000, 333, 138, 1, 0, 0));
        vecs.push_back(row(0, 1, 1,   3'b000, 3'b010, 327, 138, 1, 0, 0));
        vecs.push_back(row(0, 1, 1,   3'b010, 3'b000, 333, 138, 1, 0, 0));
        vecs.push_back(row(0, 1, 1,   3'b000, 3'b000, 339, 138, 1, 0, 0));
        vecs.push_back(row(0, 1, 27,  3'b000, 3'b000, 501, 138, 1, 0, 0));

        reset = 1'b1; en = 1'b0; serve = 1'b0;
        {l_tophit, l_midhit, l_bothit} = 3'b000;
        {r_tophit, r_midhit, r_bothit} = 3'b000;
        x = 10'd0; y = 10'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ball_x", int'(ball_x), 395);
        chk("reset_ball_y", int'(ball_y), 319);
        chk("reset_playing", int'(playing), 0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].cnt; k++) begin
                cycle(vecs[i].en, vecs[i].serve, vecs[i].lf, vecs[i].rf);
            end
            chk($sformatf("row%0d_ball_x", i), int'(ball_x), vecs[i].ex);
            chk($sformatf("row%0d_ball_y", i), int'(ball_y), vecs[i].ey);
            chk($sformatf("row%0d_playing", i), int'(playing), int'(vecs[i].play));
            chk($sformatf("row%0d_score_left", i), int'(score_left), int'(vecs[i].sl));
            chk($sformatf("row%0d_score_right", i), int'(score_right), int'(vecs[i].sr));
        end

        // Asynchronous reset mid-PLAY: outputs must change before the next edge.
        en = 1'b0;
        reset = 1'b1;
        #1;
        chk("async_reset_ball_x", int'(ball_x), 395);
        chk("async_reset_ball_y", int'(ball_y), 319);
        chk("async_reset_playing", int'(playing), 0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Flag priority: mid beats top/bot on the right, top beats bot on the left.
        cycle(1'b0, 1'b1, 3'b000, 3'b000);
        cycle(1'b1, 1'b0, 3'b000, 3'b111);
        chk("prio_mid_x", int'(ball_x), 392);
        chk("prio_mid_y", int'(ball_y), 319);
        cycle(1'b1, 1'b0, 3'b101, 3'b000);
        chk("prio_top_x", int'(ball_x), 396);
        chk("prio_top_y", int'(ball_y), 317);

        // Pixel hit box around the ball at its current position.
        dxs = '{0, 9, 10, -1, 0, 5};
        dys = '{0, 9, 0, 0, 10, -1};
        for (int i = 0; i < 6; i++) begin
            px = m_x + dxs[i];
            py = m_y + dys[i];
            x = 10'(px);
            y = 10'(py);
            #1;
            exp_rgb = (px >= m_x && px < m_x + 10 && py >= m_y && py < m_y + 10) ? 32'hfff : 0;
            chk($sformatf("rgb_%0d", i), int'(rgb), exp_rgb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
